// File: rtl/endstop_homing_if.sv
// Arm request and trigger-report channels of the endstop homing block.
// The host side uses master, the homing block uses slave.
interface endstop_homing_if #(
    parameter int NENDSTOP    = 4,
    parameter int NSTEPDIR    = 6,
    parameter int SAMPLE_BITS = 24,
    parameter int TICK_BITS   = 16
);
    localparam int CH_BITS = (NENDSTOP > 1) ? $clog2(NENDSTOP) : 1;

    logic                   arm_valid;
    logic                   arm_ready;
    logic [CH_BITS-1:0]     arm_chan;
    logic [31:0]            arm_time;
    logic [SAMPLE_BITS-1:0] arm_sample_count;
    logic [TICK_BITS-1:0]   arm_sample_ticks;
    logic                   arm_pin_value;
    logic [NSTEPDIR-1:0]    arm_stepper_mask;

    logic                   evt_valid;
    logic                   evt_ready;
    logic [CH_BITS-1:0]     evt_chan;
    logic [31:0]            evt_time;

    modport master (
        output arm_valid, arm_chan, arm_time, arm_sample_count,
        output arm_sample_ticks, arm_pin_value, arm_stepper_mask,
        input  arm_ready,
        input  evt_valid, evt_chan, evt_time,
        output evt_ready
    );

    modport slave (
        input  arm_valid, arm_chan, arm_time, arm_sample_count,
        input  arm_sample_ticks, arm_pin_value, arm_stepper_mask,
        output arm_ready,
        output evt_valid, evt_chan, evt_time,
        input  evt_ready
    );
endinterface

// File: rtl/endstop_homing.sv
// Per-channel endstop homing: waits for a start time, debounces the pin over
// N samples, pulses stepper resets and reports the trigger timestamp.
module endstop_homing #(
    parameter int NENDSTOP    = 4,
    parameter int NSTEPDIR    = 6,
    parameter int SAMPLE_BITS = 24,
    parameter int TICK_BITS   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         systime_i,
    input  logic [NENDSTOP-1:0] endstop_in_i,
    endstop_homing_if.slave     bus,
    output logic [NSTEPDIR-1:0] step_reset_o,
    output logic [NENDSTOP-1:0] homing_o,
    output logic [NENDSTOP-1:0] endstop_sync_o,
    output logic                missed_clock_o
);
    localparam int CH_BITS = (NENDSTOP > 1) ? $clog2(NENDSTOP) : 1;
    localparam logic [31:0] LATE_LIM = 32'hC000_0000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_CLOCK,
        S_REST,
        S_SAMPLE,
        S_REPORT
    } state_t;

    state_t                 state_q   [NENDSTOP];
    state_t                 state_d   [NENDSTOP];
    logic [SAMPLE_BITS-1:0] cnt_q     [NENDSTOP];
    logic [SAMPLE_BITS-1:0] cnt_d     [NENDSTOP];
    logic [SAMPLE_BITS-1:0] count_q   [NENDSTOP];
    logic [SAMPLE_BITS-1:0] count_d   [NENDSTOP];
    logic [TICK_BITS-1:0]   tick_q    [NENDSTOP];
    logic [TICK_BITS-1:0]   tick_d    [NENDSTOP];
    logic [TICK_BITS-1:0]   ticks_q   [NENDSTOP];
    logic [TICK_BITS-1:0]   ticks_d   [NENDSTOP];
    logic [31:0]            time_q    [NENDSTOP];
    logic [31:0]            time_d    [NENDSTOP];
    logic [31:0]            trig_q    [NENDSTOP];
    logic [31:0]            trig_d    [NENDSTOP];
    logic [NSTEPDIR-1:0]    mask_q    [NENDSTOP];
    logic [NSTEPDIR-1:0]    mask_d    [NENDSTOP];
    logic [NENDSTOP-1:0]    pin_q;
    logic [NENDSTOP-1:0]    pin_d;

    logic [NENDSTOP-1:0]    sync1_q;
    logic [NENDSTOP-1:0]    sync2_q;

    logic [NSTEPDIR-1:0]    step_q;
    logic [NSTEPDIR-1:0]    step_d;
    logic                   missed_q;
    logic                   missed_d;
    logic                   evt_valid_q;
    logic                   evt_valid_d;
    logic [CH_BITS-1:0]     evt_chan_q;
    logic [CH_BITS-1:0]     evt_chan_d;
    logic [31:0]            evt_time_q;
    logic [31:0]            evt_time_d;

    logic                   arm_fire;
    logic                   arm_late;
    logic                   arm_cancel;
    logic [TICK_BITS-1:0]   arm_ticks;
    logic [NENDSTOP-1:0]    arm_hit;
    logic [NENDSTOP-1:0]    take;
    logic                   out_free;
    logic                   found;

    assign bus.arm_ready  = !rst;
    assign bus.evt_valid  = evt_valid_q;
    assign bus.evt_chan   = evt_chan_q;
    assign bus.evt_time   = evt_time_q;
    assign step_reset_o   = step_q;
    assign missed_clock_o = missed_q;
    assign endstop_sync_o = sync2_q;

    // Armed flag: a channel is homing while it waits or samples.
    always_comb begin
        homing_o = '0;
        for (int c = 0; c < NENDSTOP; c++) begin
            homing_o[c] = (state_q[c] == S_WAIT_CLOCK) ||
                          (state_q[c] == S_REST) ||
                          (state_q[c] == S_SAMPLE);
        end
    end

    // Next state: per-channel FSMs, report arbiter and output register.
    always_comb begin
        arm_fire   = bus.arm_valid && bus.arm_ready;
        arm_late   = (bus.arm_time - systime_i) >= LATE_LIM;
        arm_cancel = (bus.arm_sample_count == '0);
        arm_ticks  = (bus.arm_sample_ticks == '0) ?
                     TICK_BITS'(1) : bus.arm_sample_ticks;
        out_free   = !evt_valid_q || bus.evt_ready;

        arm_hit = '0;
        for (int c = 0; c < NENDSTOP; c++) begin
            arm_hit[c] = arm_fire && (32'(bus.arm_chan) == 32'(c));
        end

        missed_d = missed_q;
        if ((arm_hit != '0) && !arm_cancel && arm_late) begin
            missed_d = 1'b1;
        end

        // Output register: clears on transfer, refills from lowest channel.
        evt_valid_d = evt_valid_q;
        evt_chan_d  = evt_chan_q;
        evt_time_d  = evt_time_q;
        if (evt_valid_q && bus.evt_ready) begin
            evt_valid_d = 1'b0;
            evt_chan_d  = '0;
            evt_time_d  = '0;
        end
        take  = '0;
        found = 1'b0;
        for (int c = 0; c < NENDSTOP; c++) begin
            if (out_free && !found &&
                (state_q[c] == S_REPORT) && !arm_hit[c]) begin
                found       = 1'b1;
                take[c]     = 1'b1;
                evt_valid_d = 1'b1;
                evt_chan_d  = CH_BITS'(c);
                evt_time_d  = trig_q[c];
            end
        end

        step_d = '0;
        pin_d  = pin_q;
        for (int c = 0; c < NENDSTOP; c++) begin
            logic smp;
            logic hit;
            logic trg;
            smp = (tick_q[c] == '0);
            hit = (sync2_q[c] == pin_q[c]);
            trg = 1'b0;

            state_d[c] = state_q[c];
            cnt_d[c]   = cnt_q[c];
            count_d[c] = count_q[c];
            tick_d[c]  = tick_q[c];
            ticks_d[c] = ticks_q[c];
            time_d[c]  = time_q[c];
            trig_d[c]  = trig_q[c];
            mask_d[c]  = mask_q[c];

            unique case (state_q[c])
                S_IDLE: begin
                end
                S_WAIT_CLOCK: begin
                    if (systime_i == time_q[c]) begin
                        state_d[c] = S_REST;
                    end
                end
                S_REST, S_SAMPLE: begin
                    tick_d[c] = smp ? ticks_q[c] - TICK_BITS'(1) :
                                      tick_q[c] - TICK_BITS'(1);
                    if (smp && state_q[c] == S_REST && hit) begin
                        cnt_d[c] = count_q[c] - SAMPLE_BITS'(1);
                        if (count_q[c] == SAMPLE_BITS'(1)) begin
                            trg = 1'b1;
                        end else begin
                            state_d[c] = S_SAMPLE;
                        end
                    end
                    if (smp && state_q[c] == S_SAMPLE) begin
                        if (!hit) begin
                            state_d[c] = S_REST;
                        end else begin
                            cnt_d[c] = cnt_q[c] - SAMPLE_BITS'(1);
                            trg = (cnt_q[c] == SAMPLE_BITS'(1));
                        end
                    end
                    if (trg) begin
                        state_d[c] = S_REPORT;
                        trig_d[c]  = systime_i;
                    end
                end
                S_REPORT: begin
                    if (take[c]) begin
                        state_d[c] = S_IDLE;
                    end
                end
                default: begin
                    state_d[c] = S_IDLE;
                end
            endcase

            // An arm on this channel overrides whatever it was doing.
            if (arm_hit[c]) begin
                trg = 1'b0;
                if (arm_cancel) begin
                    state_d[c] = S_IDLE;
                end else begin
                    state_d[c] = arm_late ? S_REST : S_WAIT_CLOCK;
                    cnt_d[c]   = '0;
                    count_d[c] = bus.arm_sample_count;
                    tick_d[c]  = '0;
                    ticks_d[c] = arm_ticks;
                    time_d[c]  = bus.arm_time;
                    mask_d[c]  = bus.arm_stepper_mask;
                    pin_d[c]   = bus.arm_pin_value;
                end
            end

            if (trg) begin
                step_d = step_d | mask_q[c];
            end
        end
    end

    // State registers, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            step_q      <= '0;
            missed_q    <= 1'b0;
            evt_valid_q <= 1'b0;
            evt_chan_q  <= '0;
            evt_time_q  <= '0;
            pin_q       <= '0;
            for (int c = 0; c < NENDSTOP; c++) begin
                state_q[c] <= S_IDLE;
                cnt_q[c]   <= '0;
                count_q[c] <= '0;
                tick_q[c]  <= '0;
                ticks_q[c] <= '0;
                time_q[c]  <= '0;
                trig_q[c]  <= '0;
                mask_q[c]  <= '0;
            end
        end else begin
            sync1_q     <= endstop_in_i;
            sync2_q     <= sync1_q;
            step_q      <= step_d;
            missed_q    <= missed_d;
            evt_valid_q <= evt_valid_d;
            evt_chan_q  <= evt_chan_d;
            evt_time_q  <= evt_time_d;
            pin_q       <= pin_d;
            for (int c = 0; c < NENDSTOP; c++) begin
                state_q[c] <= state_d[c];
                cnt_q[c]   <= cnt_d[c];
                count_q[c] <= count_d[c];
                tick_q[c]  <= tick_d[c];
                ticks_q[c] <= ticks_d[c];
                time_q[c]  <= time_d[c];
                trig_q[c]  <= trig_d[c];
                mask_q[c]  <= mask_d[c];
            end
        end
    end
endmodule

// File: tb/tb_endstop_homing.sv
// Scenario bench for endstop_homing: expected events and step pulses are
// queued at arm time and matched against what the monitor records.
module tb_endstop_homing;
    localparam int NE = 4;
    localparam int NS = 6;
    localparam int SB = 24;
    localparam int TB = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   systime = '0;
    logic [NE-1:0] endstop = '0;
    logic [NS-1:0] step_reset;
    logic [NE-1:0] homing;
    logic [NE-1:0] esync;
    logic          missed;

    endstop_homing_if #(
        .NENDSTOP(NE), .NSTEPDIR(NS), .SAMPLE_BITS(SB), .TICK_BITS(TB)
    ) bus ();

    endstop_homing #(
        .NENDSTOP(NE), .NSTEPDIR(NS), .SAMPLE_BITS(SB), .TICK_BITS(TB)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .systime_i      (systime),
        .endstop_in_i   (endstop),
        .bus            (bus),
        .step_reset_o   (step_reset),
        .homing_o       (homing),
        .endstop_sync_o (esync),
        .missed_clock_o (missed)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  ch;
        logic [31:0] t;
    } ev_t;

    typedef struct packed {
        logic [5:0]  m;
        logic [31:0] t;
    } st_t;

    ev_t exp_ev[$];
    ev_t obs_ev[$];
    st_t exp_st[$];
    st_t obs_st[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    // Record every handshake transfer and every step pulse.
    always @(negedge clk) begin
        if (bus.evt_valid && bus.evt_ready)
            obs_ev.push_back({bus.evt_chan, bus.evt_time});
        if (step_reset != '0)
            obs_st.push_back({step_reset, systime});
    end

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
            systime = systime + 1;
        end
    endtask

    task automatic arm(int ch, logic [31:0] t, int cnt, int tk,
                       logic pin, logic [5:0] m);
        bus.arm_valid        = 1'b1;
        bus.arm_chan         = 2'(ch);
        bus.arm_time         = t;
        bus.arm_sample_count = 24'(cnt);
        bus.arm_sample_ticks = 16'(tk);
        bus.arm_pin_value    = pin;
        bus.arm_stepper_mask = m;
        tick();
        bus.arm_valid = 1'b0;
    endtask

    task automatic test_reset();
        bus.arm_valid = 1'b0;
        bus.arm_chan = '0;
        bus.arm_time = '0;
        bus.arm_sample_count = '0;
        bus.arm_sample_ticks = '0;
        bus.arm_pin_value = 1'b0;
        bus.arm_stepper_mask = '0;
        bus.evt_ready = 1'b1;
        rst = 1'b1;
        tick(3);
        n_cmp++;
        if (bus.arm_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_arm_ready: got %b want 0", bus.arm_ready);
        end
        n_cmp++;
        if ({step_reset, homing, esync, missed, bus.evt_valid,
             bus.evt_chan, bus.evt_time} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: step %h hom %h sync %h mc %b ev %b",
                     step_reset, homing, esync, missed, bus.evt_valid);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (bus.arm_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL run_arm_ready: got %b want 1", bus.arm_ready);
        end
        endstop = 4'b1010;
        tick();
        n_cmp++;
        if (esync !== 4'b0000) begin
            n_bad++;
            $display("FAIL sync_stage1: got %b want 0000", esync);
        end
        tick();
        n_cmp++;
        if (esync !== 4'b1010) begin
            n_bad++;
            $display("FAIL sync_stage2: got %b want 1010", esync);
        end
        endstop = '0;
        tick(3);
    endtask

    task automatic test_basic();
        logic [31:0] s0;
        ev_t eo, ee;
        st_t so, se;
        s0 = systime;
        exp_ev.push_back({2'd1, s0 + 32'd103});
        exp_st.push_back({6'b000100, s0 + 32'd104});
        arm(1, s0 + 32'd100, 3, 1, 1'b1, 6'b000100);
        tick(49);
        endstop[1] = 1'b1;
        n_cmp++;
        if (homing !== 4'b0010 || missed !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_homing: hom %b mc %b want 0010 0",
                     homing, missed);
        end
        tick(70);
        n_cmp++;
        if (homing !== 4'b0000) begin
            n_bad++;
            $display("FAIL basic_done: hom %b want 0000", homing);
        end
        n_cmp++;
        if (obs_ev.size() != exp_ev.size() ||
            obs_st.size() != exp_st.size()) begin
            n_bad++;
            $display("FAIL basic_counts: ev %0d st %0d want %0d %0d",
                     obs_ev.size(), obs_st.size(),
                     exp_ev.size(), exp_st.size());
        end
        while (obs_ev.size() > 0 && exp_ev.size() > 0) begin
            eo = obs_ev.pop_front();
            ee = exp_ev.pop_front();
            n_cmp++;
            if (eo !== ee) begin
                n_bad++;
                $display("FAIL basic_evt: got ch%0d t%0d want ch%0d t%0d",
                         eo.ch, eo.t, ee.ch, ee.t);
            end
        end
        while (obs_st.size() > 0 && exp_st.size() > 0) begin
            so = obs_st.pop_front();
            se = exp_st.pop_front();
            n_cmp++;
            if (so !== se) begin
                n_bad++;
                $display("FAIL basic_step: got %b@%0d want %b@%0d",
                         so.m, so.t, se.m, se.t);
            end
        end
        exp_ev.delete(); obs_ev.delete();
        exp_st.delete(); obs_st.delete();
    endtask

    task automatic test_bounce();
        logic [31:0] s0;
        ev_t eo, ee;
        st_t so, se;
        s0 = systime;
        exp_ev.push_back({2'd2, s0 + 32'd91});
        exp_st.push_back({6'b000010, s0 + 32'd92});
        arm(2, s0 + 32'd20, 4, 10, 1'b1, 6'b000010);
        tick(9);
        endstop[2] = 1'b1;
        tick(25);
        endstop[2] = 1'b0;
        tick(10);
        n_cmp++;
        if (obs_st.size() != 0 || homing[2] !== 1'b1) begin
            n_bad++;
            $display("FAIL bounce_nopulse: pulses %0d hom %b want 0 1",
                     obs_st.size(), homing[2]);
        end
        tick(10);
        endstop[2] = 1'b1;
        tick(45);
        n_cmp++;
        if (obs_ev.size() != exp_ev.size() ||
            obs_st.size() != exp_st.size()) begin
            n_bad++;
            $display("FAIL bounce_counts: ev %0d st %0d want %0d %0d",
                     obs_ev.size(), obs_st.size(),
                     exp_ev.size(), exp_st.size());
        end
        while (obs_ev.size() > 0 && exp_ev.size() > 0) begin
            eo = obs_ev.pop_front();
            ee = exp_ev.pop_front();
            n_cmp++;
            if (eo !== ee) begin
                n_bad++;
                $display("FAIL bounce_evt: got ch%0d t%0d want ch%0d t%0d",
                         eo.ch, eo.t, ee.ch, ee.t);
            end
        end
        while (obs_st.size() > 0 && exp_st.size() > 0) begin
            so = obs_st.pop_front();
            se = exp_st.pop_front();
            n_cmp++;
            if (so !== se) begin
                n_bad++;
                $display("FAIL bounce_step: got %b@%0d want %b@%0d",
                         so.m, so.t, se.m, se.t);
            end
        end
        exp_ev.delete(); obs_ev.delete();
        exp_st.delete(); obs_st.delete();
    endtask

    task automatic test_late_cancel();
        logic [31:0] s0;
        ev_t eo, ee;
        st_t so, se;
        endstop = 4'b0001;
        tick(3);
        s0 = systime;
        exp_ev.push_back({2'd0, s0 + 32'd2});
        exp_st.push_back({6'b000001, s0 + 32'd3});
        arm(0, s0 - 32'd5, 2, 1, 1'b1, 6'b000001);
        n_cmp++;
        if (missed !== 1'b1 || homing[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL late_flag: mc %b hom %b want 1 1",
                     missed, homing[0]);
        end
        tick(5);
        arm(3, systime + 32'd1000, 5, 1, 1'b1, 6'b100000);
        n_cmp++;
        if (homing[3] !== 1'b1) begin
            n_bad++;
            $display("FAIL cancel_armed: hom3 %b want 1", homing[3]);
        end
        arm(3, 32'd0, 0, 1, 1'b1, 6'b100000);
        n_cmp++;
        if (homing[3] !== 1'b0 || missed !== 1'b1) begin
            n_bad++;
            $display("FAIL cancel_idle: hom3 %b mc %b want 0 1",
                     homing[3], missed);
        end
        tick(20);
        n_cmp++;
        if (obs_ev.size() != exp_ev.size() ||
            obs_st.size() != exp_st.size()) begin
            n_bad++;
            $display("FAIL late_counts: ev %0d st %0d want %0d %0d",
                     obs_ev.size(), obs_st.size(),
                     exp_ev.size(), exp_st.size());
        end
        while (obs_ev.size() > 0 && exp_ev.size() > 0) begin
            eo = obs_ev.pop_front();
            ee = exp_ev.pop_front();
            n_cmp++;
            if (eo !== ee) begin
                n_bad++;
                $display("FAIL late_evt: got ch%0d t%0d want ch%0d t%0d",
                         eo.ch, eo.t, ee.ch, ee.t);
            end
        end
        while (obs_st.size() > 0 && exp_st.size() > 0) begin
            so = obs_st.pop_front();
            se = exp_st.pop_front();
            n_cmp++;
            if (so !== se) begin
                n_bad++;
                $display("FAIL late_step: got %b@%0d want %b@%0d",
                         so.m, so.t, se.m, se.t);
            end
        end
        exp_ev.delete(); obs_ev.delete();
        exp_st.delete(); obs_st.delete();
    endtask

    task automatic test_back_to_back();
        logic [31:0] t0;
        ev_t eo, ee;
        st_t so, se;
        endstop = 4'b0000;
        tick(3);
        t0 = systime + 32'd20;
        exp_st.push_back({6'b100001, t0 + 32'd3});
        exp_ev.push_back({2'd0, t0 + 32'd2});
        exp_ev.push_back({2'd3, t0 + 32'd2});
        arm(0, t0, 2, 1, 1'b0, 6'b000001);
        arm(3, t0, 2, 1, 1'b0, 6'b100000);
        bus.evt_ready = 1'b0;
        tick(23);
        for (int i = 0; i < 20; i++) begin
            n_cmp++;
            if ({bus.evt_valid, bus.evt_chan, bus.evt_time} !==
                {1'b1, 2'd0, t0 + 32'd2}) begin
                n_bad++;
                $display("FAIL hold_ch0[%0d]: v%b ch%0d t%0d want 1 0 %0d",
                         i, bus.evt_valid, bus.evt_chan, bus.evt_time,
                         t0 + 32'd2);
            end
            tick();
        end
        bus.evt_ready = 1'b1;
        tick();
        n_cmp++;
        if ({bus.evt_valid, bus.evt_chan, bus.evt_time} !==
            {1'b1, 2'd3, t0 + 32'd2}) begin
            n_bad++;
            $display("FAIL next_ch3: v%b ch%0d t%0d want 1 3 %0d",
                     bus.evt_valid, bus.evt_chan, bus.evt_time, t0 + 32'd2);
        end
        tick();
        n_cmp++;
        if (bus.evt_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL drained: v%b want 0", bus.evt_valid);
        end
        tick(3);
        n_cmp++;
        if (obs_ev.size() != exp_ev.size() ||
            obs_st.size() != exp_st.size()) begin
            n_bad++;
            $display("FAIL b2b_counts: ev %0d st %0d want %0d %0d",
                     obs_ev.size(), obs_st.size(),
                     exp_ev.size(), exp_st.size());
        end
        while (obs_ev.size() > 0 && exp_ev.size() > 0) begin
            eo = obs_ev.pop_front();
            ee = exp_ev.pop_front();
            n_cmp++;
            if (eo !== ee) begin
                n_bad++;
                $display("FAIL b2b_evt: got ch%0d t%0d want ch%0d t%0d",
                         eo.ch, eo.t, ee.ch, ee.t);
            end
        end
        while (obs_st.size() > 0 && exp_st.size() > 0) begin
            so = obs_st.pop_front();
            se = exp_st.pop_front();
            n_cmp++;
            if (so !== se) begin
                n_bad++;
                $display("FAIL b2b_step: got %b@%0d want %b@%0d",
                         so.m, so.t, se.m, se.t);
            end
        end
        exp_ev.delete(); obs_ev.delete();
        exp_st.delete(); obs_st.delete();
    endtask

    task automatic test_reset_mid();
        logic [31:0] s0;
        st_t so, se;
        endstop = 4'b0100;
        tick(3);
        bus.evt_ready = 1'b0;
        s0 = systime;
        exp_st.push_back({6'b000010, s0 + 32'd3});
        arm(2, s0 - 32'd1, 5, 1, 1'b1, 6'b000100);
        arm(1, s0, 1, 1, 1'b0, 6'b000010);
        tick(2);
        n_cmp++;
        if (bus.evt_valid !== 1'b1 || bus.evt_chan !== 2'd1 ||
            homing[2] !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_pending: v%b ch%0d hom2 %b want 1 1 1",
                     bus.evt_valid, bus.evt_chan, homing[2]);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (bus.arm_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_arm_ready: got %b want 0", bus.arm_ready);
        end
        tick();
        rst = 1'b0;
        n_cmp++;
        if ({step_reset, homing, esync, missed, bus.evt_valid,
             bus.evt_chan, bus.evt_time} !== '0) begin
            n_bad++;
            $display("FAIL mid_cleared: step %h hom %h sync %h mc %b ev %b",
                     step_reset, homing, esync, missed, bus.evt_valid);
        end
        bus.evt_ready = 1'b1;
        tick(20);
        n_cmp++;
        if (obs_ev.size() != 0 || obs_st.size() != exp_st.size() ||
            homing !== 4'b0000) begin
            n_bad++;
            $display("FAIL mid_quiet: ev %0d st %0d hom %b want 0 %0d 0000",
                     obs_ev.size(), obs_st.size(), homing, exp_st.size());
        end
        while (obs_st.size() > 0 && exp_st.size() > 0) begin
            so = obs_st.pop_front();
            se = exp_st.pop_front();
            n_cmp++;
            if (so !== se) begin
                n_bad++;
                $display("FAIL mid_step: got %b@%0d want %b@%0d",
                         so.m, so.t, se.m, se.t);
            end
        end
        exp_ev.delete(); obs_ev.delete();
        exp_st.delete(); obs_st.delete();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bounce();
        test_late_cancel();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/endstop_homing.md
ENDSTOP_HOMING -- requirements
Module: endstop_homing

Interface
REQ-001 Parameter NENDSTOP, default 4: number of endstop channels, 1..16.
REQ-002 Parameter NSTEPDIR, default 6: number of stepper channels whose reset can be driven.
REQ-003 Parameter SAMPLE_BITS, default 24: width of the sample counter.
REQ-004 Parameter TICK_BITS, default 16: width of the sample-interval counter. CH_BITS = max(1, clog2(NENDSTOP)).
REQ-005 clk  in  1  sole clock; all logic on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 systime  in  32  free-running system time.
REQ-008 endstop_in  in  NENDSTOP  asynchronous endstop pins.
REQ-009 arm_valid / arm_ready  in / out  1 / 1  arm handshake; transfer occurs when both are high.
REQ-010 arm_chan, arm_time, arm_sample_count, arm_sample_ticks, arm_pin_value, arm_stepper_mask  in  CH_BITS, 32, SAMPLE_BITS, TICK_BITS, 1, NSTEPDIR  arm arguments.
REQ-011 step_reset  out  NSTEPDIR  one-cycle pulse per triggered stepper.
REQ-012 evt_valid / evt_ready  out / in  1 / 1  trigger-report handshake.
REQ-013 evt_chan, evt_time  out  CH_BITS, 32  reported channel and trigger timestamp.
REQ-014 homing  out  NENDSTOP  per-channel armed flag (state not IDLE or REPORT).
REQ-015 endstop_sync  out  NENDSTOP  synchronised pin values.
REQ-016 missed_clock  out  1  sticky flag for late arm time.

Function
REQ-017 endstop_in shall pass through a 2-flop synchroniser; endstop_sync shall be the second stage, with 2 cycles of latency.
REQ-018 arm_ready shall be 1 whenever rst is low; an arm transfer shall take effect on the next cycle.
REQ-019 Each channel shall run its own FSM with states IDLE, WAIT_CLOCK, REST, SAMPLE and REPORT.
REQ-020 Arm with arm_sample_count == 0 shall force the channel to IDLE and discard any unreported event for that channel (cancel).
REQ-021 Arm with a non-zero sample count shall latch all arguments, reload the tick counter, and enter WAIT_CLOCK.
REQ-022 Late arm: if (arm_time - systime) mod 2^32 >= 0xC0000000 at the transfer cycle, the channel shall enter REST directly and missed_clock shall be set to 1.
REQ-023 WAIT_CLOCK -> REST when systime == latched time.
REQ-024 The channel shall evaluate a sample once every max(arm_sample_ticks, 1) cycles while in REST or SAMPLE, using a per-channel tick down-counter.
REQ-025 REST, on a sample with endstop_sync == pin_value: load cnt = sample_count - 1; if the result is 0, trigger immediately; otherwise go to SAMPLE.
REQ-026 SAMPLE, on a sample with endstop_sync != pin_value: return to REST.
REQ-027 SAMPLE, on a sample with a match: decrement cnt; trigger when cnt reaches 0. Exactly sample_count consecutive matching samples are therefore needed.
REQ-028 Trigger: in the cycle after the final matching sample, step_reset shall pulse the latched stepper mask, ORed across all channels triggering in the same cycle.
REQ-029 Trigger: systime of the final matching sample shall be captured, and the FSM shall go to REPORT.
REQ-030 Report arbiter: when the output register is empty, it shall load the lowest-index channel in REPORT. That channel shall go to IDLE; evt_valid shall rise the following cycle.
REQ-031 evt_chan and evt_time shall hold stable while evt_valid && !evt_ready; the output register shall clear on the cycle of transfer.
REQ-032 Back-to-back transfers: a new event may load on the same cycle the previous one transfers, giving one event per cycle maximum.
REQ-033 Re-arm of a channel already in WAIT_CLOCK, REST or SAMPLE shall replace its parameters and restart at WAIT_CLOCK (or REST if the arm is late).
REQ-034 Re-arm of a channel in REPORT shall drop the unsent event; an event already in the output register shall be unaffected.
REQ-035 Arm with arm_chan >= NENDSTOP shall be accepted and ignored.
REQ-036 missed_clock shall clear only on rst.

Reset
REQ-037 On rst high, all FSMs shall go to IDLE and all counters and latched arguments shall clear to 0.
REQ-038 On rst high, step_reset, evt_valid, evt_chan, evt_time, homing, missed_clock and the synchroniser flops shall all be 0.
REQ-039 rst high mid-homing or with evt_valid pending shall abort all activity; no step_reset pulse shall occur from rst.
REQ-040 arm_ready shall be 0 while rst is high.

Verification
REQ-041 Basic trigger: arm ch1, time = systime+100, count = 3, ticks = 1, pin = 1, mask = 6'b000100; drive pin 1 high from systime+50 -> 3 samples after WAIT_CLOCK exit, a single step_reset = 000100 pulse, then evt_chan = 1 with evt_time = systime of the third sample.
REQ-042 Bounce: count = 4, ticks = 10, pin toggles after 2 matching samples -> FSM returns to REST with no pulse; a later stable level triggers after 4 samples 10 cycles apart.
REQ-043 Late arm: arm_time = systime - 5 -> missed_clock = 1 and sampling starts the next cycle; cancel (count = 0) on another channel -> that channel's homing = 0 and no event.
REQ-044 Simultaneous triggers: ch0 and ch3 trigger in the same cycle with masks 000001 and 100000 and evt_ready held low for 20 cycles -> step_reset = 100001 once; ch0 reported first and held stable, then ch3 on the next cycle after ready.
REQ-045 Reset mid-operation: rst pulsed while ch2 is in SAMPLE and an event is pending -> all outputs 0 the next cycle, no events afterwards.
